// File: rtl/btn_pkg.sv
// Shared types, default parameters and helpers for the button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int N_BTN_DEF    = 5;
  localparam int DEBOUNCE_DEF = 500000;
  localparam int HOLD_DEF     = 50000000;
  localparam int REPEAT_DEF   = 10000000;

  function automatic int cnt_w(input int max_v);
    return (max_v < 2) ? 1 : $clog2(max_v);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter,
// auto-repeat FSM and registered press/release/repeat strobes.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int HOLD_CYCLES     = HOLD_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic rpt_o
);

  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(RMAX);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] H_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  rpt_state_e    state_q, state_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rpt_q, rpt_d;
  logic          rise, fall;

  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    level_d = level_q;
    dcnt_d  = dcnt_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (sync2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == D_LAST) begin
      level_d = ~level_q;
      dcnt_d  = '0;
      rise    = ~level_q;
      fall    = level_q;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  // A release flip always beats a repeat terminal count.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HOLD;
          rcnt_d  = '0;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == H_LAST) begin
          state_d = REPEAT;
          rcnt_d  = '0;
          rpt_d   = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == R_LAST) begin
          rcnt_d = '0;
          rpt_d  = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  assign press_d = rise;
  assign rel_d   = fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      state_q <= IDLE;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign rpt_o   = rpt_q;

endmodule

// File: rtl/btn_conditioner.sv
// Array of independent button channels feeding the menu/game FSMs.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int HOLD_CYCLES     = HOLD_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .press_o(btn_press[i]),
      .rel_o  (btn_release[i]),
      .rpt_o  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised + directed bench for btn_conditioner against a
// history-based reference model.
module tb_btn_conditioner;

  localparam int N  = 5;
  localparam int TD = 4;
  localparam int TH = 10;
  localparam int TR = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;

  int checks   = 0;
  int failures = 0;

  btn_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(TD),
    .HOLD_CYCLES    (TH),
    .REPEAT_CYCLES  (TR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: a new level is accepted once the last TD
  // synchronised samples all disagree with the current level.
  logic [N-1:0]  m_s1, m_s2;
  logic [TD-1:0] hist [N];
  int            hv [N];
  logic [N-1:0]  m_level, m_press, m_rel, m_rpt;
  int            pressed_at [N];
  int            mcyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1    <= '0;
      m_s2    <= '0;
      m_level <= '0;
      m_press <= '0;
      m_rel   <= '0;
      m_rpt   <= '0;
      for (int c = 0; c < N; c++) begin
        hist[c] <= '0;
        hv[c]   <= 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        automatic logic [TD-1:0] h;
        automatic int v;
        automatic logic fl;
        automatic int k;
        h  = {hist[c][TD-2:0], m_s2[c]};
        v  = (hv[c] < TD) ? hv[c] + 1 : TD;
        fl = (v == TD) && (h == {TD{~m_level[c]}});
        k  = mcyc - pressed_at[c];
        hist[c]    <= h;
        hv[c]      <= v;
        m_press[c] <= fl && !m_level[c];
        m_rel[c]   <= fl && m_level[c];
        if (fl) m_level[c] <= ~m_level[c];
        if (fl && !m_level[c]) pressed_at[c] <= mcyc;
        m_rpt[c] <= !fl && m_level[c] && (k >= TH) &&
                    (((k - TH) % TR) == 0);
      end
      m_s2 <= m_s1;
      m_s1 <= btn_raw;
      mcyc <= mcyc + 1;
    end
  end

  int press_cnt [N];
  int rpt_cnt [N];
  int last_press [N];
  int rpt2 [$];
  int ncyc = 0;

  initial begin
    for (int c = 0; c < N; c++) begin
      press_cnt[c]  = 0;
      rpt_cnt[c]    = 0;
      last_press[c] = 0;
    end
  end

  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      chk("level", 32'(btn_level), 32'(m_level));
      chk("press", 32'(btn_press), 32'(m_press));
      chk("release", 32'(btn_release), 32'(m_rel));
      chk("repeat", 32'(btn_repeat), 32'(m_rpt));
    end
    for (int c = 0; c < N; c++) begin
      if (btn_press[c]) begin
        press_cnt[c]++;
        last_press[c] = ncyc;
      end
      if (btn_repeat[c]) rpt_cnt[c]++;
    end
    if (btn_repeat[2]) rpt2.push_back(ncyc);
  end

  int run [N];
  int p2;

  initial begin
    rst_n   = 1'b0;
    btn_raw = '0;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_strobes", 32'(btn_press | btn_release | btn_repeat), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // clean press on channel 0
    btn_raw[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("clean_level_early", 32'(btn_level), 0);
    @(posedge clk);
    #1 chk("clean_press", 32'(btn_press), 32'h01);
    chk("clean_level", 32'(btn_level), 32'h01);
    @(posedge clk);
    #1 chk("clean_press_1cyc", 32'(btn_press), 0);
    repeat (14) @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("clean_cnt0", press_cnt[0], 1);
    chk("clean_others",
        press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4], 0);

    // bounce rejection on channel 1
    for (int i = 0; i < 4; i++) begin
      btn_raw[1] = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    btn_raw[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_level", 32'(btn_level[1]), 0);
    chk("bounce_none", press_cnt[1], 0);
    for (int i = 0; i < 4; i++) begin
      btn_raw[1] = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    btn_raw[1] = 1'b1;
    repeat (8) @(negedge clk);
    chk("bounce_one_press", press_cnt[1], 1);
    btn_raw[1] = 1'b0;
    repeat (10) @(negedge clk);

    // auto-repeat on channel 2
    rpt2.delete();
    btn_raw[2] = 1'b1;
    repeat (7) @(negedge clk);
    p2 = last_press[2];
    chk("rpt_pressed", press_cnt[2], 1);
    repeat (30) @(negedge clk);
    btn_raw[2] = 1'b0;
    repeat (10) @(negedge clk);
    chk("rpt_count_ge4", 32'(rpt2.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      if (i < rpt2.size())
        chk($sformatf("rpt_off%0d", i), rpt2[i] - p2, TH + i * TR);

    // release flip lands on a repeat terminal count (channel 3)
    btn_raw[3] = 1'b1;
    repeat (6) @(negedge clk);
    repeat (7) @(negedge clk);
    btn_raw[3] = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("coll_release", 32'(btn_release[3]), 1);
    chk("coll_no_repeat", 32'(btn_repeat[3]), 0);
    chk("coll_level", 32'(btn_level[3]), 0);
    repeat (20) @(posedge clk);
    #1 chk("coll_rpt_total", rpt_cnt[3], 1);

    // reset while channel 0 is in auto-repeat
    @(negedge clk);
    btn_raw[0] = 1'b1;
    repeat (21) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rstmid_level", 32'(btn_level), 0);
    chk("rstmid_press", 32'(btn_press), 0);
    chk("rstmid_release", 32'(btn_release), 0);
    chk("rstmid_repeat", 32'(btn_repeat), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("rstmid_early", 32'(btn_press[0]), 0);
    @(posedge clk);
    #1 chk("rstmid_repress", 32'(btn_press[0]), 1);
    @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (10) @(negedge clk);

    // concurrent presses on channels 0 and 4
    btn_raw[0] = 1'b1;
    btn_raw[4] = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("concurrent_press", 32'(btn_press), 32'h11);
    @(negedge clk);
    btn_raw = '0;
    repeat (10) @(negedge clk);

    // randomised bouncing, checked every cycle by the model
    for (int c = 0; c < N; c++) run[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      if (t == 1500) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (run[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          if ($urandom_range(0, 3) == 0)
            run[c] = $urandom_range(10, 40);
          else
            run[c] = $urandom_range(1, 5);
        end else begin
          run[c]--;
        end
      end
    end
    btn_raw = '0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Per-button input conditioner between the board push-buttons and the single-flop pulse stage that feeds the menu and game FSMs. Each channel synchronises a raw button, debounces it with a stability counter, and emits a clean level plus one-cycle press, release and auto-repeat strobes. Downstream logic consumes `btn_press`/`btn_repeat` directly and never sees bounce or metastability.

## Interface
- `N_BTN`, 5: number of independent button channels (Basys3 C/U/L/R/D).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new level; minimum 2.
- `HOLD_CYCLES`, 50000000: cycles from press to first repeat strobe; minimum 2.
- `REPEAT_CYCLES`, 10000000: cycles between subsequent repeat strobes; minimum 2.
- `clk`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  N_BTN  unsynchronised button pins.
- `btn_level`  out  N_BTN  debounced level.
- `btn_press`  out  N_BTN  one-cycle strobe on accepted 0→1.
- `btn_release`  out  N_BTN  one-cycle strobe on accepted 1→0.
- `btn_repeat`  out  N_BTN  one-cycle strobe while held (auto-repeat).

## Operation
- Reset (async assert, sync-safe deassert handled at top): sync flops, counters, `btn_level`, all strobes = 0; FSM = IDLE.
- Synchroniser: two flops per channel; `s` = second flop.
- Debounce: counter `dcnt`. If `s == level`, `dcnt <= 0`. Else if `dcnt == DEBOUNCE_CYCLES-1`, flip `level`, `dcnt <= 0`. Else `dcnt++`. Any glitch shorter than DEBOUNCE_CYCLES cycles at `s` resets the count and is never seen.
- Strobes are registered: `btn_press` is high for the single cycle in which `level` first reads 1. `btn_release` behaves the same way on a 1→0 flip.
- Repeat FSM, per channel:
  - IDLE: `level` = 0. On the press flip, clear `rcnt` and go to HOLD.
  - HOLD: `rcnt++`. When `rcnt == HOLD_CYCLES-1`, assert `btn_repeat` for one cycle, clear `rcnt`, and go to REPEAT.
  - REPEAT: `rcnt++`. When `rcnt == REPEAT_CYCLES-1`, assert `btn_repeat` and clear `rcnt`.
  - HOLD/REPEAT: a release flip returns to IDLE and clears `rcnt`.
- Simultaneous release flip and repeat terminal count: release wins, and no `btn_repeat` is issued that cycle.
- `btn_press`, `btn_release` and `btn_repeat` are mutually exclusive per channel per cycle.
- Channels are fully independent; any combination may strobe in the same cycle.
- Counter widths: `$clog2` of the largest relevant parameter. Counters never wrap: they are cleared at their terminal count.

## Timing
- Raw edge stable before sampling edge E1: `s` changes after E2, and `level` plus the press/release strobe update after edge E(DEBOUNCE_CYCLES+2).
- Total latency is DEBOUNCE_CYCLES+2 cycles.
- First `btn_repeat` comes HOLD_CYCLES cycles after the `btn_press` cycle. Later strobes are spaced REPEAT_CYCLES apart.
- Reset mid-hold: outputs drop to 0 immediately. After `rst_n` rises with the button still held, the channel re-debounces and issues a fresh `btn_press` DEBOUNCE_CYCLES+2 cycles later.

## Structure
- Package `btn_pkg`:
  - state enum {IDLE, HOLD, REPEAT};
  - default parameter constants;
  - a `cnt_w(max)` width function.
- Sub-module `btn_channel`: one channel containing synchroniser, debounce, FSM and strobes.
- `btn_conditioner` contains only a generate loop of N_BTN `btn_channel` instances.

## Test plan
All scenarios use N_BTN=5, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Clean press: `btn_raw[0]` 0→1 held 20 cycles → `btn_level[0]` and `btn_press[0]` rise 6 cycles after E1. `btn_press[0]` lasts exactly 1 cycle. Other channels stay 0.
- Bounce rejection: `btn_raw[1]` toggles 1,0,1,0 at 3-cycle spacing, then returns to 0 → no strobe and `btn_level[1]` = 0. Bounce followed by 1 held ≥6 cycles → exactly one press.
- Auto-repeat: hold `btn_raw[2]` for 30 cycles after press → repeats at press+10, +13, +16, +19, ….
- Release/repeat collision: release timed so the release flip lands on a repeat terminal count → `btn_release` = 1, `btn_repeat` = 0 that cycle, FSM returns to IDLE.
- Reset mid-hold: assert `rst_n`=0 during REPEAT → all outputs 0 asynchronously. Deassert with button held → new press 6 cycles later.
- Concurrent channels: press channels 0 and 4 on the same edge → both `btn_press` strobes fire in the same cycle.
